alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Generic WIDTH and a valid/ready handshake on both input and output.
- Adds arithmetic shift and full flag outputs (carry, zero, negative, overflow, error).
- Adds an optional iterative shift-add multiplier.
- Sits between the operand/decode stage and writeback. Downstream backpressure stalls the block.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH), width of the effective shift-amount field (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B / shift amount.
- fun  input  4  opcode.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream consumes the result.
- y  output  WIDTH  result.
- c_out  output  1  carry / no-borrow / multiply-high-nonzero.
- zero  output  1  y == 0.
- neg  output  1  y[WIDTH-1].
- ovf  output  1  signed overflow (ADD/SUB only, else 0).
- err  output  1  illegal opcode flag for this result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: y=0, all flags=0, out_valid=0, FSM=IDLE, multiplier counter=0.
- in_ready is 0 while rst is high.
- Reset mid-multiply aborts the operation with no output.
- Accept on in_valid && in_ready at a rising edge. Operands and opcode are latched on accept. Later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0.
  - DONE: out_valid=1; outputs held stable until out_ready.
  - BUSY: multiply in progress; in_ready=0, out_valid=0.
- in_ready = (IDLE) || (DONE && out_ready).
  - Back-to-back single-cycle ops sustain 1 result per cycle under continuous out_ready.
- Transitions:
  - IDLE + accept of single-cycle op -> DONE.
  - IDLE + accept of MUL -> BUSY.
  - DONE + out_ready + accept -> DONE (single-cycle op) or BUSY (MUL).
  - DONE + out_ready, no accept -> IDLE.
  - DONE, out_ready=0 -> DONE (hold).
  - BUSY with counter == WIDTH-1 -> DONE.
- Latency: single-cycle ops accepted at edge N present out_valid=1 after edge N. MUL presents out_valid after edge N+WIDTH.
- Opcodes (y is WIDTH bits, wraps modulo 2^WIDTH):
  - 0000 ADD: {c_out,y}=a+b; ovf = a,b same sign and y sign differs.
  - 0001 SUB: y=a-b; c_out=1 when a>=b unsigned (no borrow); ovf = a,b signs differ and y sign != a sign.
  - 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift amount is the full unsigned b.
    - b >= WIDTH: SLL/SRL give 0; SRA gives all copies of a[WIDTH-1].
  - 1000 MUL (see Optional Feature).
  - Any other opcode: y=0, err=1, other flags 0, latency 1.
- Flag rules:
  - zero/neg are always computed from the final y.
  - c_out=0 and ovf=0 for logic ops and shifts.
  - err=0 for legal ops.
- Simultaneous out_ready and new accept in DONE: the old result retires and the new one is captured on the same edge. No bubble, no duplication.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 1000 is MUL, unsigned, radix-2 shift-add, one bit of b per cycle, WIDTH cycles.
  - Internal 2*WIDTH accumulator.
  - y = low WIDTH bits; c_out = 1 if the high WIDTH bits are nonzero.
  - ovf=0, err=0.
- Undefined: no multiplier logic and no BUSY-state datapath.
  - Opcode 1000 is illegal: y=0, err=1, latency 1.

Test Plan:
- Reset, then WIDTH=32 ADD a=FFFFFFFF b=00000001, out_ready=1 -> one cycle later: out_valid=1, y=0, c_out=1, zero=1, ovf=0.
- SUB a=80000000 b=00000001 -> y=7FFFFFFF, c_out=1, ovf=1, neg=0. Then SUB a=1 b=2 -> y=FFFFFFFF, c_out=0, neg=1.
- SRA a=80000000 b=4 -> y=F8000000. SRA b=40 -> y=FFFFFFFF. SLL a=1 b=32 -> y=0, zero=1.
- Stream 4 ADDs back-to-back with out_ready=1 -> 4 results on 4 consecutive cycles, in_ready constant 1. Then hold out_ready=0 for 3 cycles -> y/flags stable, in_ready=0, no result lost.
- With ALU_SEQ_MUL_EN: MUL a=0001_0000 b=0001_0000 -> out_valid exactly 32 cycles after accept, y=0, c_out=1, in_ready=0 during BUSY. Assert rst mid-MUL -> out_valid=0, IDLE next cycle.
- Without ALU_SEQ_MUL_EN: fun=1000, and separately fun=1111 -> y=0, err=1, latency 1. Repeat ADD test with WIDTH=8: a=7F b=01 -> y=80, ovf=1, neg=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with valid/ready handshakes on both sides and full flag outputs.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier on opcode 1000.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       fun,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             c_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   state_t           state_r;
   state_t           state_nxt_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             is_mul_s;
   logic [WIDTH-1:0] y_r;
   logic             c_r, zero_r, neg_r, ovf_r, err_r;
   logic [WIDTH-1:0] res_y_s;
   logic             res_c_s, res_ovf_s, res_err_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic             big_sh_s;
   logic [SHW-1:0]   shamt_s;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic [SHW-1:0]     cnt_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] prod_nxt_s;
   logic               mul_last_s;

   assign is_mul_s   = (fun == 4'b1000);
   assign mul_last_s = (state_r == BUSY) && (cnt_r == CNT_LAST);
`else
   assign is_mul_s = 1'b0;
`endif

   assign in_ready_s = !rst && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
   assign accept_s   = in_valid && in_ready_s;
   assign in_ready   = in_ready_s;
   assign out_valid  = (state_r == DONE);
   assign y          = y_r;
   assign c_out      = c_r;
   assign zero       = zero_r;
   assign neg        = neg_r;
   assign ovf        = ovf_r;
   assign err        = err_r;

   // Single-cycle result and flags from the live operands; only captured on accept.
   always_comb begin
      res_y_s   = '0;
      res_c_s   = 1'b0;
      res_ovf_s = 1'b0;
      res_err_s = 1'b0;
      sum_s     = {1'b0, a} + {1'b0, b};
      diff_s    = {1'b0, a} - {1'b0, b};
      big_sh_s  = (b >= WIDTH_V);
      shamt_s   = b[SHW-1:0];
      case (fun)
         4'b0000: begin
            res_y_s   = sum_s[WIDTH-1:0];
            res_c_s   = sum_s[WIDTH];
            res_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0001: begin
            res_y_s   = diff_s[WIDTH-1:0];
            res_c_s   = ~diff_s[WIDTH];
            res_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0010: res_y_s = a & b;
         4'b0011: res_y_s = a | b;
         4'b0100: res_y_s = a ^ b;
         4'b0101: begin
            if (big_sh_s) res_y_s = '0;
            else          res_y_s = a << shamt_s;
         end
         4'b0110: begin
            if (big_sh_s) res_y_s = '0;
            else          res_y_s = a >> shamt_s;
         end
         4'b0111: begin
            if (big_sh_s) res_y_s = {WIDTH{a[WIDTH-1]}};
            else          res_y_s = $unsigned($signed(a) >>> shamt_s);
         end
         default: res_err_s = 1'b1;
      endcase
   end

   // Next-state logic for the IDLE/BUSY/DONE handshake controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = is_mul_s ? BUSY : DONE;
            else          state_nxt_s = IDLE;
         end
         DONE: begin
            if (accept_s)       state_nxt_s = is_mul_s ? BUSY : DONE;
            else if (out_ready) state_nxt_s = IDLE;
            else                state_nxt_s = DONE;
         end
         BUSY: begin
`ifdef ALU_SEQ_MUL_EN
            if (mul_last_s) state_nxt_s = DONE;
            else            state_nxt_s = BUSY;
`else
            state_nxt_s = IDLE;
`endif
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

`ifdef ALU_SEQ_MUL_EN
   // One shift-add step: add the multiplicand into the high half when the current b bit is set.
   always_comb begin
      mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, (prod_r[0] ? mcand_r : {WIDTH{1'b0}})};
      prod_nxt_s = {mul_sum_s, prod_r[WIDTH-1:1]};
   end

   // Multiplier operand latch, product accumulator and step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= '0;
         prod_r  <= '0;
         mcand_r <= '0;
      end else if (accept_s && is_mul_s) begin
         cnt_r   <= '0;
         prod_r  <= {{WIDTH{1'b0}}, b};
         mcand_r <= a;
      end else if (state_r == BUSY) begin
         cnt_r  <= mul_last_s ? {SHW{1'b0}} : cnt_r + 1'b1;
         prod_r <= prod_nxt_s;
      end
   end
`endif

   // Result and flag registers; held while the result waits in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r    <= '0;
         c_r    <= 1'b0;
         zero_r <= 1'b0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
         err_r  <= 1'b0;
      end else if (accept_s && !is_mul_s) begin
         y_r    <= res_y_s;
         c_r    <= res_c_s;
         zero_r <= (res_y_s == {WIDTH{1'b0}});
         neg_r  <= res_y_s[WIDTH-1];
         ovf_r  <= res_ovf_s;
         err_r  <= res_err_s;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_last_s) begin
         y_r    <= prod_nxt_s[WIDTH-1:0];
         c_r    <= |prod_nxt_s[2*WIDTH-1:WIDTH];
         zero_r <= (prod_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
         neg_r  <= prod_nxt_s[WIDTH-1];
         ovf_r  <= 1'b0;
         err_r  <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances) against an
// arithmetic reference model; follows ALU_SEQ_MUL_EN when it is defined.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, y;
   logic [3:0]  fun;
   logic        c_out, zero, neg, ovf, err;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, y8;
   logic [3:0]  fun8;
   logic        c8, z8, n8, o8, e8;

   int checks   = 0;
   int failures = 0;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .fun(fun), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .c_out(c_out), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .fun(fun8), .out_valid(out_valid8), .out_ready(out_ready8),
      .y(y8), .c_out(c8), .zero(z8), .neg(n8), .ovf(o8), .err(e8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: operands as w-bit unsigned numbers, signed views via two's complement value.
   function automatic void ref_alu(input int w, input logic [3:0] f, input logic [63:0] av,
                                   input logic [63:0] bv, output logic [63:0] ey,
                                   output logic ec, output logic eo, output logic ee);
      logic [63:0] mask, s, p;
      longint      sa, sb, r, maxp;
      mask = (64'd1 << w) - 64'd1;
      maxp = longint'(mask >> 1);
      sa = av[w-1] ? longint'(av) - longint'(64'd1 << w) : longint'(av);
      sb = bv[w-1] ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
      ey = 64'd0; ec = 1'b0; eo = 1'b0; ee = 1'b0;
      case (f)
         4'd0: begin
            s = av + bv; ey = s & mask; ec = (s >> w) != 64'd0;
            r = sa + sb; eo = (r > maxp) || (r < -maxp - 1);
         end
         4'd1: begin
            ey = (av - bv) & mask; ec = (av >= bv);
            r = sa - sb; eo = (r > maxp) || (r < -maxp - 1);
         end
         4'd2: ey = av & bv;
         4'd3: ey = av | bv;
         4'd4: ey = av ^ bv;
         4'd5: ey = (bv >= 64'(w)) ? 64'd0 : (av << bv) & mask;
         4'd6: ey = (bv >= 64'(w)) ? 64'd0 : (av >> bv);
         4'd7: begin
            if (bv >= 64'(w)) ey = (sa < 0) ? mask : 64'd0;
            else              ey = 64'(sa >>> bv) & mask;
         end
         4'd8: begin
            if (MUL_ON) begin
               p = av * bv; ey = p & mask; ec = (p >> w) != 64'd0;
            end else begin
               ee = 1'b1;
            end
         end
         default: ee = 1'b1;
      endcase
   endfunction

   // Issue one op to the 32-bit instance from a negedge; returns at the negedge showing the result.
   task automatic op32(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
      logic [63:0] ey;
      logic        ec, eo, ee;
      int          lat, exp_lat;
      ref_alu(32, f, {32'd0, av}, {32'd0, bv}, ey, ec, eo, ee);
      exp_lat = (MUL_ON && f == 4'b1000) ? 32 : 1;
      out_ready = 1'b1; in_valid = 1'b1; a = av; b = bv; fun = f;
      #1;
      check("in_ready32", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; fun = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         check("busy_in_ready32", in_ready, 0);
         @(negedge clk);
         lat++;
      end
      check("latency32", lat, exp_lat);
      check("y32", y, ey);
      check("c32", c_out, ec);
      check("zero32", zero, ey == 64'd0);
      check("neg32", neg, ey[31]);
      check("ovf32", ovf, eo);
      check("err32", err, ee);
   endtask

   task automatic op8(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv);
      logic [63:0] ey;
      logic        ec, eo, ee;
      int          lat, exp_lat;
      ref_alu(8, f, {56'd0, av}, {56'd0, bv}, ey, ec, eo, ee);
      exp_lat = (MUL_ON && f == 4'b1000) ? 8 : 1;
      out_ready8 = 1'b1; in_valid8 = 1'b1; a8 = av; b8 = bv; fun8 = f;
      #1;
      check("in_ready8", in_ready8, 1);
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!out_valid8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency8", lat, exp_lat);
      check("y8", y8, ey);
      check("c8", c8, ec);
      check("zero8", z8, ey == 64'd0);
      check("neg8", n8, ey[7]);
      check("ovf8", o8, eo);
      check("err8", e8, ee);
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] sa[5], sb[5];
      logic [63:0] ey;
      logic        ec, eo, ee;
      int          seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; fun = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; fun8 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_flags", {c_out, zero, neg, ovf, err}, 0);
      check("rst_out_valid8", out_valid8, 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      // Directed cases with hand-computed expectations on top of the model check.
      op32(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
      check("tp_add_y", y, 32'h0);
      check("tp_add_flags", {c_out, zero, ovf}, 3'b110);
      op32(4'b0001, 32'h8000_0000, 32'h0000_0001);
      check("tp_sub_y", y, 32'h7FFF_FFFF);
      check("tp_sub_flags", {c_out, ovf, neg}, 3'b110);
      op32(4'b0001, 32'h0000_0001, 32'h0000_0002);
      check("tp_sub2", {y, c_out, neg}, {32'hFFFF_FFFF, 2'b01});
      op32(4'b0111, 32'h8000_0000, 32'd4);
      check("tp_sra4", y, 32'hF800_0000);
      op32(4'b0111, 32'h8000_0000, 32'd40);
      check("tp_sra40", y, 32'hFFFF_FFFF);
      op32(4'b0101, 32'h0000_0001, 32'd32);
      check("tp_sll32", {y, zero}, {32'h0, 1'b1});
      op32(4'b1111, 32'h1234_5678, 32'h1);
      check("tp_illegal", {y, err}, {32'h0, 1'b1});
      op32(4'b1000, 32'h0001_0000, 32'h0001_0000);
      check("tp_op8_y", y, 32'h0);
      check("tp_op8_flag", MUL_ON ? c_out : err, 1);

      // Back-to-back stream of four ADDs, then a stall with a fifth op pending.
      for (int i = 0; i < 5; i++) begin
         sa[i] = $urandom; sb[i] = $urandom;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = sa[i]; b = sb[i]; fun = 4'b0000;
         #1;
         check("stream_in_ready", in_ready, 1);
         @(negedge clk);
         ref_alu(32, 4'b0000, {32'd0, sa[i]}, {32'd0, sb[i]}, ey, ec, eo, ee);
         check("stream_valid", out_valid, 1);
         check("stream_y", y, ey);
      end
      in_valid = 1'b1; a = sa[4]; b = sb[4]; fun = 4'b0001; out_ready = 1'b0;
      ref_alu(32, 4'b0000, {32'd0, sa[3]}, {32'd0, sb[3]}, ey, ec, eo, ee);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_in_ready", in_ready, 0);
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_y", y, ey);
         check("stall_c", c_out, ec);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      ref_alu(32, 4'b0001, {32'd0, sa[4]}, {32'd0, sb[4]}, ey, ec, eo, ee);
      check("release_valid", out_valid, 1);
      check("release_y", y, ey);

      // Reset while a result is held.
      op32(4'b0011, 32'h8000_0000, 32'h0000_0001);
      out_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_done_valid", out_valid, 0);
      check("rst_done_y", y, 0);
      check("rst_done_neg", neg, 0);
      check("rst_done_in_ready", in_ready, 0);
      rst = 1'b0; out_ready = 1'b1;

      if (MUL_ON) begin
         in_valid = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000; fun = 4'b1000;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (5) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("mul_rst_valid", out_valid, 0);
         rst = 1'b0;
         #1;
         check("mul_rst_in_ready", in_ready, 1);
         seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         check("mul_abort", seen, 0);
      end

      op8(4'b0000, 8'h7F, 8'h01);
      check("tp8_add", {y8, o8, n8}, {8'h80, 2'b11});

      for (int i = 0; i < 150; i++) begin
         op32(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8)), pick32(), pick32());
      end
      for (int i = 0; i < 60; i++) begin
         op8(4'($urandom), 8'($urandom), ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
